aes_iter_round_engine: RTL

- Iterative AES encryption datapath that reuses one round per clock for all Nr rounds.
- Successor to the fixed, single-round 128-bit mid-round block: key length is parametrised (128/192/256), rounds are sequenced by an internal FSM, and the last round omits MixColumns.
- Data moves on valid/ready handshakes in both directions.
- Round keys come from an external key store, indexed by this block.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_round_comb.sv | 35 +++
 rtl/aes_iter_round_engine.sv | 98 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and helpers: S-box table, GF(2^8) xtime, round count per key length,
// 128-bit state and round-index typedefs, and the engine FSM encoding.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [3:0]   round_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } eng_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nr_for_key(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (bypassed on the
// last round), AddRoundKey. Byte i of the state is bits [127-8i -: 8], column-major.
module aes_round_comb
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t rk,
    input  logic       last,
    output aes_state_t next_state
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = SBOX[state[127-8*i -: 8]];
    end

    // Row r of column c comes from column (c+r) mod 4
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[c*4+r] = sb[((c+r)%4)*4+r];
        end
        assign mc[c*4+0] = xtime(sr[c*4+0]) ^ xtime(sr[c*4+1]) ^ sr[c*4+1] ^ sr[c*4+2] ^ sr[c*4+3];
        assign mc[c*4+1] = sr[c*4+0] ^ xtime(sr[c*4+1]) ^ xtime(sr[c*4+2]) ^ sr[c*4+2] ^ sr[c*4+3];
        assign mc[c*4+2] = sr[c*4+0] ^ sr[c*4+1] ^ xtime(sr[c*4+2]) ^ xtime(sr[c*4+3]) ^ sr[c*4+3];
        assign mc[c*4+3] = xtime(sr[c*4+0]) ^ sr[c*4+0] ^ sr[c*4+1] ^ sr[c*4+2] ^ xtime(sr[c*4+3]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign next_state[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
    end

endmodule

// File: rtl/aes_iter_round_engine.sv
// Iterative AES encryptor, one round per clock, valid/ready in and out, round keys fetched
// from an external store via rk_idx. AES_KEY_WHITEN_EN: apply round key 0 on accept.
module aes_iter_round_engine
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         asy_reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy
);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_iter_round_engine: KEY_BITS must be 128, 192 or 256");
    end

    localparam int     NR   = nr_for_key(KEY_BITS);
    localparam round_t NR_R = round_t'(NR);

    eng_state_e state, state_nxt;
    round_t     round;
    aes_state_t state_reg, rnd_out, init_state;
    logic       last;

    assign last = (round == NR_R);

    aes_round_comb u_round (
        .state     (state_reg),
        .rk        (rk),
        .last      (last),
        .next_state(rnd_out)
    );

`ifdef AES_KEY_WHITEN_EN
    assign init_state = pt ^ rk;
`else
    // Upstream delivers an already-whitened block; rk is ignored while idle
    assign init_state = pt;
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = round;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                rk_idx   = '0;
                if (in_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // round parks at NR through DONE so rk_idx never exceeds NR
    always_ff @(posedge clk) begin
        if (asy_reset) begin
            state     <= ST_IDLE;
            round     <= '0;
            state_reg <= '0;
            ct        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (in_valid) begin
                    state_reg <= init_state;
                    round     <= 4'd1;
                end
                ST_RUN: begin
                    state_reg <= rnd_out;
                    if (last) ct <= rnd_out;
                    else      round <= round + 4'd1;
                end
                ST_DONE: if (out_ready) round <= '0;
                default: round <= '0;
            endcase
        end
    end

endmodule
